// File: rtl/imm_encoder_pkg.sv
// Shared immediate-format definitions for the RV32IM immediate encoder and
// the ID-stage immediate decoder: format codes, the unsigned/raw flag
// position, the range-check helper and the decoder itself.
package imm_pkg;

    // Low three bits of IMM_SEL select the instruction format.
    localparam logic [2:0] FMT_U     = 3'b000;
    localparam logic [2:0] FMT_J     = 3'b001;
    localparam logic [2:0] FMT_I     = 3'b010;
    localparam logic [2:0] FMT_B     = 3'b011;
    localparam logic [2:0] FMT_S     = 3'b100;
    localparam logic [2:0] FMT_SHAMT = 3'b101;

    // IMM_SEL bit that selects unsigned (I/S) or raw (J) interpretation.
    localparam int SEL_FLAG_BIT = 3;

    // One beat as captured by the first pipeline stage.
    typedef struct packed {
        logic [3:0]  sel;
        logic [31:0] imm;
        logic [31:0] base;
    } imm_beat_t;

    // True when v is representable in nbits: as a two's-complement value
    // (everything from bit nbits-1 upward is a copy of the sign) or as an
    // unsigned value (everything from bit nbits upward is zero).
    function automatic logic range_ok(input logic [31:0] v,
                                      input int unsigned nbits,
                                      input logic is_signed);
        logic signed [31:0] sv;
        logic [31:0]        hi;
        if (is_signed) begin
            sv = $signed(v);
            hi = sv >>> (nbits - 1);
            return (hi == '0) || (hi == '1);
        end
        hi = v >> nbits;
        return hi == '0;
    endfunction

    // ID-stage immediate generator: recovers the immediate carried by an
    // instruction word for the given IMM_SEL code.
    function automatic logic [31:0] sign_extend(input logic [31:0] inst,
                                                input logic [3:0] sel);
        logic raw;
        raw = sel[SEL_FLAG_BIT];
        case (sel[2:0])
            FMT_U:     return {inst[31:12], 12'h000};
            FMT_J:     return raw ? {11'h000, inst[31:12], 1'b0}
                                  : {{11{inst[31]}}, inst[31], inst[19:12],
                                     inst[20], inst[30:21], 1'b0};
            FMT_I:     return raw ? {20'h00000, inst[31:20]}
                                  : {{20{inst[31]}}, inst[31:20]};
            FMT_B:     return {{19{inst[31]}}, inst[31], inst[7],
                               inst[30:25], inst[11:8], 1'b0};
            FMT_S:     return raw ? {20'h00000, inst[31:25], inst[11:7]}
                                  : {{20{inst[31]}}, inst[31:25], inst[11:7]};
            FMT_SHAMT: return {27'h0000000, inst[24:20]};
            default:   return 32'h0000_0000;
        endcase
    endfunction

endpackage

// File: rtl/imm_encoder_if.sv
// Beat-level bus of the immediate encoder: input beat handshake with the
// format/immediate/base word, and the encoded-word output handshake.
interface imm_encoder_if;
    logic        IN_VALID;
    logic        IN_READY;
    logic [3:0]  IMM_SEL;
    logic [31:0] IMM_VAL;
    logic [31:0] BASE_INST;
    logic        OUT_VALID;
    logic        OUT_READY;
    logic [31:0] INST_OUT;
    logic        RANGE_ERR;

    // Producer of beats / consumer of encoded words.
    modport master (
        output IN_VALID, IMM_SEL, IMM_VAL, BASE_INST, OUT_READY,
        input  IN_READY, OUT_VALID, INST_OUT, RANGE_ERR
    );

    // The encoder itself.
    modport slave (
        input  IN_VALID, IMM_SEL, IMM_VAL, BASE_INST, OUT_READY,
        output IN_READY, OUT_VALID, INST_OUT, RANGE_ERR
    );
endinterface

// File: rtl/imm_encoder_pack_comb.sv
// Combinational immediate packer: scatters the immediate into the bit
// positions owned by the selected format, keeps every other bit of the base
// word, and flags immediates that the format cannot represent. On error the
// truncated immediate is still packed.
module imm_pack_comb
    import imm_pkg::*;
(
    input  logic [3:0]  sel_i,
    input  logic [31:0] imm_i,
    input  logic [31:0] base_i,
    output logic [31:0] inst_o,
    output logic        err_o
);

    logic raw;

    assign raw = sel_i[SEL_FLAG_BIT];

    // Field scatter and range check for the selected format.
    always_comb begin
        inst_o = base_i;
        err_o  = 1'b0;
        case (sel_i[2:0])
            FMT_U: begin
                inst_o[31:12] = imm_i[31:12];
                err_o         = (imm_i[11:0] != 12'h000);
            end
            FMT_J: begin
                if (raw) begin
                    inst_o[31:12] = imm_i[20:1];
                    err_o         = imm_i[0] | ~range_ok(imm_i, 21, 1'b0);
                end else begin
                    inst_o[31]    = imm_i[20];
                    inst_o[30:21] = imm_i[10:1];
                    inst_o[20]    = imm_i[11];
                    inst_o[19:12] = imm_i[19:12];
                    err_o         = imm_i[0] | ~range_ok(imm_i, 21, 1'b1);
                end
            end
            FMT_I: begin
                inst_o[31:20] = imm_i[11:0];
                err_o         = ~range_ok(imm_i, 12, ~raw);
            end
            FMT_B: begin
                inst_o[31]    = imm_i[12];
                inst_o[30:25] = imm_i[10:5];
                inst_o[11:8]  = imm_i[4:1];
                inst_o[7]     = imm_i[11];
                err_o         = imm_i[0] | ~range_ok(imm_i, 13, 1'b1);
            end
            FMT_S: begin
                inst_o[31:25] = imm_i[11:5];
                inst_o[11:7]  = imm_i[4:0];
                err_o         = ~range_ok(imm_i, 12, ~raw);
            end
            FMT_SHAMT: begin
                inst_o[24:20] = imm_i[4:0];
                err_o         = ~range_ok(imm_i, 5, 1'b0);
            end
            default: begin
                // Codes 110/111 have no immediate: pass the base through.
                inst_o = base_i;
                err_o  = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/imm_encoder.sv
// RV32IM immediate encoder: two-stage valid/ready pipeline that packs an
// immediate into a base instruction word for the selected format, flags
// unrepresentable immediates, and counts delivered words and errors.
// S1 holds the accepted beat (the range check is evaluated from it), S2 holds
// the packed word and error flag that drive the outputs.
// Optional build macro IMM_ENCODER_ROUNDTRIP_EN adds a decode-back check of
// every delivered word (output ROUNDTRIP_MISMATCH).
module imm_encoder
    import imm_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             RESET,
    imm_encoder_if.slave     bus,
    output logic [CNT_W-1:0] ENC_COUNT,
    output logic [CNT_W-1:0] ERR_COUNT
`ifdef IMM_ENCODER_ROUNDTRIP_EN
    ,
    output logic             ROUNDTRIP_MISMATCH
`endif
);

    imm_beat_t        s1_beat_q;
    logic             s1_valid_q, s1_valid_d;
    logic             s2_valid_q, s2_valid_d;
    logic [31:0]      s2_inst_q;
    logic             s2_err_q;
    logic [CNT_W-1:0] enc_cnt_q, enc_cnt_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

    logic             in_ready;
    logic             in_fire;
    logic             s1_adv;
    logic             out_fire;
    logic [31:0]      pack_inst;
    logic             pack_err;

    imm_pack_comb u_pack (
        .sel_i  (s1_beat_q.sel),
        .imm_i  (s1_beat_q.imm),
        .base_i (s1_beat_q.base),
        .inst_o (pack_inst),
        .err_o  (pack_err)
    );

    // Handshake decode and next-state for the valid flags and counters.
    always_comb begin
        in_ready   = ~s1_valid_q | ~s2_valid_q | bus.OUT_READY;
        in_fire    = bus.IN_VALID & in_ready;
        s1_adv     = s1_valid_q & (~s2_valid_q | bus.OUT_READY);
        out_fire   = s2_valid_q & bus.OUT_READY;

        s1_valid_d = in_fire | (s1_valid_q & ~s1_adv);
        s2_valid_d = s1_adv | (s2_valid_q & ~bus.OUT_READY);

        enc_cnt_d  = enc_cnt_q;
        err_cnt_d  = err_cnt_q;
        if (out_fire) begin
            enc_cnt_d = enc_cnt_q + CNT_W'(1);
            if (s2_err_q && (err_cnt_q != '1)) begin
                err_cnt_d = err_cnt_q + CNT_W'(1);
            end
        end
    end

    // ---- S1: capture the accepted beat ----
    // Beat payload only matters while s1_valid_q is set, so it needs no reset.
    always_ff @(posedge CLK) begin
        if (in_fire) begin
            s1_beat_q.sel  <= bus.IMM_SEL;
            s1_beat_q.imm  <= bus.IMM_VAL;
            s1_beat_q.base <= bus.BASE_INST;
        end
    end

    // ---- S2: packed word, valid flags and statistics ----
    // Reset drops any in-flight beat and clears the visible outputs.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            s2_inst_q  <= 32'h0000_0000;
            s2_err_q   <= 1'b0;
            enc_cnt_q  <= '0;
            err_cnt_q  <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            enc_cnt_q  <= enc_cnt_d;
            err_cnt_q  <= err_cnt_d;
            if (s1_adv) begin
                s2_inst_q <= pack_inst;
                s2_err_q  <= pack_err;
            end
        end
    end

`ifdef IMM_ENCODER_ROUNDTRIP_EN
    logic [3:0]  s2_sel_q;
    logic [31:0] s2_imm_q;
    logic [31:0] rt_decoded;
    logic        rt_diff;

    // S2 keeps the selector and original immediate for the decode-back check.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            s2_sel_q <= 4'h0;
            s2_imm_q <= 32'h0000_0000;
        end else if (s1_adv) begin
            s2_sel_q <= s1_beat_q.sel;
            s2_imm_q <= s1_beat_q.imm;
        end
    end

    // Decode the delivered word back; U format carries only imm[31:12].
    always_comb begin
        rt_decoded = sign_extend(s2_inst_q, s2_sel_q);
        if (s2_sel_q[2:0] == FMT_U) begin
            rt_diff = (rt_decoded[31:12] != s2_imm_q[31:12]);
        end else begin
            rt_diff = (rt_decoded != s2_imm_q);
        end
        ROUNDTRIP_MISMATCH = s2_valid_q & ~s2_err_q & rt_diff;
    end
`endif

    assign bus.IN_READY  = in_ready;
    assign bus.OUT_VALID = s2_valid_q;
    assign bus.INST_OUT  = s2_inst_q;
    assign bus.RANGE_ERR = s2_err_q;
    assign ENC_COUNT     = enc_cnt_q;
    assign ERR_COUNT     = err_cnt_q;

endmodule

// File: tb/tb_imm_encoder.sv
// Self-checking bench for imm_encoder. Counters are narrowed to 4 bits so
// that ENC_COUNT wrap and ERR_COUNT saturation are reachable in a short run.
// Honours IMM_ENCODER_ROUNDTRIP_EN when defined.
module tb_imm_encoder;

    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [CNT_W-1:0] enc_cnt;
    logic [CNT_W-1:0] err_cnt;
`ifdef IMM_ENCODER_ROUNDTRIP_EN
    logic             rt_mm;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [31:0] inst;
        logic        err;
    } exp_t;

    exp_t             sb_q[$];
    logic [CNT_W-1:0] exp_enc = '0;
    logic [CNT_W-1:0] exp_err = '0;

    imm_encoder_if bus();

    imm_encoder #(.CNT_W(CNT_W)) dut (
        .CLK       (clk),
        .RESET     (rst),
        .bus       (bus),
        .ENC_COUNT (enc_cnt),
        .ERR_COUNT (err_cnt)
`ifdef IMM_ENCODER_ROUNDTRIP_EN
        ,
        .ROUNDTRIP_MISMATCH (rt_mm)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic fits_s(input logic [31:0] v, input int n);
        longint x, lim;
        x   = longint'($signed(v));
        lim = longint'(1) << (n - 1);
        return (x >= -lim) && (x < lim);
    endfunction

    function automatic logic fits_u(input logic [31:0] v, input int n);
        return longint'({32'h0, v}) < (longint'(1) << n);
    endfunction

    // Reference packer: clear the bits the format owns, then OR in the fields.
    function automatic void ref_pack(input logic [3:0] sel, input logic [31:0] imm,
                                     input logic [31:0] base,
                                     output logic [31:0] inst, output logic err);
        logic raw;
        raw = sel[3];
        case (sel[2:0])
            3'd0: begin
                inst = (base & 32'h0000_0FFF) | (imm & 32'hFFFF_F000);
                err  = (imm[11:0] != 12'h0);
            end
            3'd1: begin
                if (raw) begin
                    inst = (base & 32'h0000_0FFF) | {imm[20:1], 12'h0};
                    err  = imm[0] || !fits_u(imm, 21);
                end else begin
                    inst = (base & 32'h0000_0FFF) | {imm[20], imm[10:1], imm[11], imm[19:12], 12'h0};
                    err  = imm[0] || !fits_s(imm, 21);
                end
            end
            3'd2: begin
                inst = (base & 32'h000F_FFFF) | (32'(imm[11:0]) << 20);
                err  = raw ? !fits_u(imm, 12) : !fits_s(imm, 12);
            end
            3'd3: begin
                inst = (base & 32'h01FF_F07F) | (32'({imm[12], imm[10:5]}) << 25)
                                              | (32'({imm[4:1], imm[11]}) << 7);
                err  = imm[0] || !fits_s(imm, 13);
            end
            3'd4: begin
                inst = (base & 32'h01FF_F07F) | (32'(imm[11:5]) << 25) | (32'(imm[4:0]) << 7);
                err  = raw ? !fits_u(imm, 12) : !fits_s(imm, 12);
            end
            3'd5: begin
                inst = (base & 32'hFE0F_FFFF) | (32'(imm[4:0]) << 20);
                err  = !fits_u(imm, 5);
            end
            default: begin
                inst = base;
                err  = 1'b1;
            end
        endcase
    endfunction

    // A representable immediate for the given selector.
    function automatic logic [31:0] legal_imm(input logic [3:0] sel);
        logic [31:0] r;
        r = $urandom;
        case (sel[2:0])
            3'd0:    return {r[31:12], 12'h000};
            3'd1:    return sel[3] ? {11'h0, r[20:1], 1'b0} : {{11{r[20]}}, r[20:1], 1'b0};
            3'd2,
            3'd4:    return sel[3] ? {20'h0, r[11:0]} : {{20{r[11]}}, r[11:0]};
            3'd3:    return {{19{r[12]}}, r[12:1], 1'b0};
            3'd5:    return {27'h0, r[4:0]};
            default: return r;
        endcase
    endfunction

    // Output monitor: compares every presented word with the scoreboard head
    // (every cycle, so stalled words must stay put) and pops on a handshake.
    always @(negedge clk) begin
        if (rst) begin
            sb_q.delete();
            exp_enc = '0;
            exp_err = '0;
        end else if (bus.OUT_VALID) begin
            if (sb_q.size() == 0) begin
                check("unexpected_out", 32'(bus.OUT_VALID), 32'd0);
            end else begin
                check("inst_out", bus.INST_OUT, sb_q[0].inst);
                check("range_err", 32'(bus.RANGE_ERR), 32'(sb_q[0].err));
`ifdef IMM_ENCODER_ROUNDTRIP_EN
                check("rt_mismatch", 32'(rt_mm), 32'd0);
`endif
                if (bus.OUT_READY) begin
                    exp_enc = exp_enc + CNT_W'(1);
                    if (sb_q[0].err && exp_err != '1) exp_err = exp_err + CNT_W'(1);
                    void'(sb_q.pop_front());
                end
            end
        end
    end

    // Present a beat and hold it until accepted; the expected word is queued.
    task automatic send(input logic [3:0] sel, input logic [31:0] imm, input logic [31:0] base,
                        input logic [31:0] e_inst, input logic e_err);
        int   waited;
        exp_t e;
        bus.IN_VALID  = 1'b1;
        bus.IMM_SEL   = sel;
        bus.IMM_VAL   = imm;
        bus.BASE_INST = base;
        waited = 0;
        @(negedge clk);
        while (!bus.IN_READY && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (!bus.IN_READY) begin
            check("accept_timeout", 32'(bus.IN_READY), 32'd1);
            bus.IN_VALID = 1'b0;
            return;
        end
        e.inst = e_inst;
        e.err  = e_err;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        bus.IN_VALID = 1'b0;
    endtask

    task automatic send_ref(input logic [3:0] sel, input logic [31:0] imm, input logic [31:0] base);
        logic [31:0] ei;
        logic        ee;
        ref_pack(sel, imm, base, ei, ee);
        send(sel, imm, base, ei, ee);
    endtask

    // Let everything in flight drain, then compare the counters.
    task automatic drain(input string tag);
        int waited;
        bus.OUT_READY = 1'b1;
        waited = 0;
        while ((sb_q.size() != 0 || bus.OUT_VALID) && waited < 100) begin
            @(posedge clk);
            #2;
            waited++;
        end
        check({tag, "_drain_left"}, 32'(sb_q.size()), 32'd0);
        check({tag, "_enc_cnt"}, 32'(enc_cnt), 32'(exp_enc));
        check({tag, "_err_cnt"}, 32'(err_cnt), 32'(exp_err));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        logic rnd_done;
        logic [3:0]  sel;
        logic [31:0] imm;
        int          pick;
        int          n_rand;

        bus.IN_VALID  = 1'b0;
        bus.IMM_SEL   = 4'h0;
        bus.IMM_VAL   = 32'h0;
        bus.BASE_INST = 32'h0;
        bus.OUT_READY = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_out_valid", 32'(bus.OUT_VALID), 32'd0);
        check("rst_inst_out", bus.INST_OUT, 32'h0);
        check("rst_range_err", 32'(bus.RANGE_ERR), 32'd0);
        check("rst_enc_cnt", 32'(enc_cnt), 32'd0);
        check("rst_err_cnt", 32'(err_cnt), 32'd0);
        check("rst_in_ready", 32'(bus.IN_READY), 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.OUT_READY = 1'b1;

        // I signed, latency: accepted at edge k, visible after edge k+1
        @(posedge clk);
        #1;
        bus.IN_VALID  = 1'b1;
        bus.IMM_SEL   = 4'b0010;
        bus.IMM_VAL   = 32'hFFFF_F800;
        bus.BASE_INST = 32'h0000_0013;
        @(negedge clk);
        check("lat_in_ready", 32'(bus.IN_READY), 32'd1);
        e.inst = 32'h8000_0013;
        e.err  = 1'b0;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        bus.IN_VALID = 1'b0;
        check("lat_edge_k", 32'(bus.OUT_VALID), 32'd0);
        @(posedge clk);
        #1;
        check("lat_edge_k1", 32'(bus.OUT_VALID), 32'd1);
        check("lat_inst", bus.INST_OUT, 32'h8000_0013);
        drain("lat");

        // B format: in-range and odd immediate
        send(4'b0011, 32'h0000_0FFE, 32'h0000_0063, 32'h7E00_0FE3, 1'b0);
        send(4'b0011, 32'h0000_0801, 32'h0000_0063, 32'h0000_00E3, 1'b1);
        drain("b");
        check("b_err_count_one", 32'(err_cnt), 32'd1);

        // U / SHAMT / illegal / format boundaries
        send(4'b0000, 32'h1234_5000, 32'h0000_0037, 32'h1234_5037, 1'b0);
        send(4'b0101, 32'h0000_0020, 32'h4000_5013, 32'h4000_5013, 1'b1);
        send(4'b0110, 32'h0000_0123, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b1);
        send(4'b1001, 32'h001F_FFFE, 32'h0000_006F, 32'hFFFF_F06F, 1'b0);
        send(4'b0001, 32'hFFF0_0000, 32'h0000_006F, 32'h8000_006F, 1'b0);
        send(4'b1100, 32'h0000_0FFF, 32'h0000_0023, 32'hFE00_0FA3, 1'b0);
        send(4'b0100, 32'h0000_0800, 32'h0000_0023, 32'h8000_0023, 1'b1);
        send(4'b1010, 32'h0000_1000, 32'h0000_0013, 32'h0000_0013, 1'b1);
        drain("fmt");

        // Asynchronous reset with two beats in flight
        bus.OUT_READY = 1'b0;
        send_ref(4'b0010, 32'h0000_0005, 32'h0000_0013);
        send_ref(4'b0010, 32'h0000_0006, 32'h0000_0013);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("arst_out_valid", 32'(bus.OUT_VALID), 32'd0);
        check("arst_inst_out", bus.INST_OUT, 32'h0);
        check("arst_range_err", 32'(bus.RANGE_ERR), 32'd0);
        check("arst_enc_cnt", 32'(enc_cnt), 32'd0);
        check("arst_err_cnt", 32'(err_cnt), 32'd0);
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.OUT_READY = 1'b1;
        repeat (6) @(posedge clk);
        #2;
        check("arst_quiet", 32'(bus.OUT_VALID), 32'd0);

        // Backpressure: four back-to-back beats, output stalled
        bus.OUT_READY = 1'b0;
        send_ref(4'b0010, 32'h0000_0011, 32'h0000_0013);
        send_ref(4'b0100, 32'hFFFF_FFF0, 32'h0000_0023);
        bus.IN_VALID  = 1'b1;
        bus.IMM_SEL   = 4'b0000;
        bus.IMM_VAL   = 32'hABCD_E000;
        bus.BASE_INST = 32'h0000_0037;
        check("bp_in_ready_low", 32'(bus.IN_READY), 32'd0);
        repeat (2) begin
            @(posedge clk);
            #1;
            check("bp_in_ready_held", 32'(bus.IN_READY), 32'd0);
            check("bp_out_valid", 32'(bus.OUT_VALID), 32'd1);
        end
        bus.OUT_READY = 1'b1;
        e.inst = 32'hABCD_E037;
        e.err  = 1'b0;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        bus.IN_VALID = 1'b0;
        send_ref(4'b0101, 32'h0000_001F, 32'h4000_5013);
        drain("bp");
        check("bp_enc_four", 32'(enc_cnt), 32'd4);

        // Error counter saturation and event counter wrap
        for (int i = 0; i < 20; i++) begin
            send_ref(4'b0101, 32'h0000_0020 + 32'(i), 32'h0000_5013);
        end
        drain("sat");
        check("err_saturated", 32'(err_cnt), 32'hF);
        check("enc_wrapped", 32'(enc_cnt), 32'd8);

        // Random traffic with random output backpressure
`ifdef IMM_ENCODER_ROUNDTRIP_EN
        n_rand = 1000;
`else
        n_rand = 300;
`endif
        rnd_done = 1'b0;
        fork
            begin
                for (int i = 0; i < n_rand; i++) begin
`ifdef IMM_ENCODER_ROUNDTRIP_EN
                    sel = {1'($urandom_range(0, 1)), 3'($urandom_range(0, 5))};
                    imm = legal_imm(sel);
`else
                    sel  = 4'($urandom_range(0, 15));
                    pick = $urandom_range(0, 3);
                    if (pick == 0) imm = $urandom;
                    else imm = legal_imm(sel);
                    if (pick == 1) imm = imm ^ (32'h1 << $urandom_range(0, 31));
`endif
                    send_ref(sel, imm, $urandom);
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk);
                    #1;
                    bus.OUT_READY = ($urandom_range(0, 3) != 0);
                end
            end
        join
        drain("rand");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
